// File: rtl/stack_queue_ctrl.sv
// stack_queue_ctrl: single-array FIFO / LIFO / pass-through buffer with occupancy flags and event pulses
module stack_queue_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = DEPTH - 1,
  parameter int AE_LVL = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [1:0]        opcode,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic              flushed
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LVL);
  localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_LVL);

  typedef enum logic [1:0] {M_BUF, M_LIFO, M_FIFO, M_INV} mode_e;
  typedef enum logic [1:0] {OP_NIMIC, OP_PUSH, OP_POP, OP_PUSH_POP} op_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, wp, rp, top, n_wr, n_rd;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  n_cnt;
  logic [DATA_W-1:0] n_dout;
  logic              chg, is_full, is_empty, we, n_dv, n_ov, n_uf, n_fl;

  assign chg      = mode != mode_q;
  assign is_full  = count == FULL_C;
  assign is_empty = count == '0;

  // Any mode change restarts both pointers so FIFO and LIFO never inherit each other's layout
  always_comb begin
    wp     = chg ? '0 : wr_ptr;
    rp     = chg ? '0 : rd_ptr;
    top    = wp - 1'b1;
    n_wr   = wp;
    n_rd   = rp;
    n_cnt  = count;
    n_dout = dout;
    n_dv   = 1'b0;
    n_ov   = 1'b0;
    n_uf   = 1'b0;
    n_fl   = 1'b0;
    we     = 1'b0;
    if (chg && !is_empty) begin
      n_fl  = 1'b1;
      n_cnt = '0;
    end else if (mode == M_BUF) begin
      n_dout = din;
      n_dv   = 1'b1;
    end else if (mode == M_FIFO) begin
      if (opcode == OP_PUSH) begin
        n_ov  = is_full;
        we    = !is_full;
        n_wr  = is_full ? wp : wp + 1'b1;
        n_cnt = is_full ? count : count + 1'b1;
      end else if (opcode == OP_POP) begin
        n_uf   = is_empty;
        n_dv   = !is_empty;
        n_dout = is_empty ? dout : mem[rp];
        n_rd   = is_empty ? rp : rp + 1'b1;
        n_cnt  = is_empty ? count : count - 1'b1;
      end else if (opcode == OP_PUSH_POP) begin
        n_dv   = 1'b1;
        n_dout = is_empty ? din : mem[rp];
        we     = !is_empty;
        n_wr   = is_empty ? wp : wp + 1'b1;
        n_rd   = is_empty ? rp : rp + 1'b1;
      end
    end else if (mode == M_LIFO) begin
      n_rd = '0;
      if (opcode == OP_PUSH) begin
        n_ov  = is_full;
        we    = !is_full;
        n_wr  = is_full ? wp : wp + 1'b1;
        n_cnt = is_full ? count : count + 1'b1;
      end else if (opcode == OP_POP) begin
        n_uf   = is_empty;
        n_dv   = !is_empty;
        n_dout = is_empty ? dout : mem[top];
        n_wr   = is_empty ? wp : top;
        n_cnt  = is_empty ? count : count - 1'b1;
      end else if (opcode == OP_PUSH_POP) begin
        n_dv   = 1'b1;
        n_dout = din;
      end
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      dout         <= '0;
      dout_valid   <= 1'b0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      flushed      <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mode_q       <= M_INV;
    end else begin
      dout         <= n_dout;
      dout_valid   <= n_dv;
      count        <= n_cnt;
      full         <= n_cnt == FULL_C;
      empty        <= n_cnt == '0;
      almost_full  <= n_cnt >= AF_C;
      almost_empty <= n_cnt <= AE_C;
      overflow     <= n_ov;
      underflow    <= n_uf;
      flushed      <= n_fl;
      wr_ptr       <= n_wr;
      rd_ptr       <= n_rd;
      mode_q       <= mode;
    end

  always_ff @(posedge clk)
    if (we) mem[wp] <= din;
endmodule

// File: tb/tb_stack_queue_ctrl.sv
// tb_stack_queue_ctrl: directed self-checking bench for stack_queue_ctrl (DEPTH=8, DATA_W=32)
module tb_stack_queue_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mode = 2'd2;
  logic [1:0]  opcode = 2'd0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic [3:0]  count;
  logic        dout_valid, full, empty, almost_full, almost_empty, overflow, underflow, flushed;
  int          n_chk = 0;
  int          n_fail = 0;

  localparam logic [1:0] BUF = 2'd0, LIFO = 2'd1, FIFO = 2'd2, INV = 2'd3;
  localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, PP = 2'd3;

  stack_queue_ctrl dut (
    .clk(clk), .reset(reset), .mode(mode), .opcode(opcode), .din(din),
    .dout(dout), .dout_valid(dout_valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .flushed(flushed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] op, input logic [31:0] d);
    opcode = op;
    din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_pulses", {overflow, underflow, flushed}, 0);
    reset = 1'b1;
    step(NOP, 0);
    check("fifo_enter_noflush", flushed, 0);
    for (int i = 1; i <= 8; i++) begin
      step(PUSH, 32'h11 * i);
      check("fifo_push_count", count, i);
      check("fifo_push_af", almost_full, i >= 7);
      check("fifo_push_full", full, i == 8);
      check("fifo_push_ae", almost_empty, i <= 1);
    end
    step(PUSH, 32'h77);
    check("fifo_ovf", overflow, 1);
    check("fifo_ovf_count", count, 8);
    step(NOP, 0);
    check("fifo_ovf_pulse", overflow, 0);
    check("nop_dv", dout_valid, 0);
    step(PP, 32'h99);
    check("fifo_pp_full_dout", dout, 32'h11);
    check("fifo_pp_full_dv", dout_valid, 1);
    check("fifo_pp_full_count", count, 8);
    check("fifo_pp_full_full", full, 1);
    for (int i = 2; i <= 8; i++) begin
      step(POP, 0);
      check("fifo_pop_dout", dout, 32'h11 * i);
      check("fifo_pop_dv", dout_valid, 1);
      check("fifo_pop_count", count, 9 - i);
    end
    step(POP, 0);
    check("fifo_pop_last", dout, 32'h99);
    check("fifo_empty", empty, 1);
    step(POP, 0);
    check("fifo_udf", underflow, 1);
    check("fifo_udf_dout", dout, 32'h99);
    check("fifo_udf_dv", dout_valid, 0);
    step(PP, 32'h5);
    check("fifo_bypass_dout", dout, 32'h5);
    check("fifo_bypass_dv", dout_valid, 1);
    check("fifo_bypass_count", count, 0);
    step(PUSH, 1);
    step(PUSH, 2);
    step(PUSH, 3);
    check("pre_flush_count", count, 3);
    mode = LIFO;
    step(PUSH, 32'h44);
    check("flush_pulse", flushed, 1);
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_dv", dout_valid, 0);
    mode = FIFO;
    step(NOP, 0);
    check("empty_switch_noflush", flushed, 0);
    mode = LIFO;
    step(NOP, 0);
    check("empty_switch2_noflush", flushed, 0);
    step(PUSH, 32'hA);
    step(PUSH, 32'hB);
    step(PUSH, 32'hC);
    check("lifo_count", count, 3);
    for (int i = 0; i < 3; i++) begin
      step(POP, 0);
      check("lifo_pop_dout", dout, 32'hC - i);
      check("lifo_pop_dv", dout_valid, 1);
    end
    step(POP, 0);
    check("lifo_udf", underflow, 1);
    check("lifo_udf_dout", dout, 32'hA);
    step(PP, 32'h77);
    check("lifo_pp_dout", dout, 32'h77);
    check("lifo_pp_count", count, 0);
    step(PUSH, 32'h1);
    step(PUSH, 32'h2);
    step(PP, 32'h66);
    check("lifo_pp_mid_dout", dout, 32'h66);
    check("lifo_pp_mid_count", count, 2);
    step(POP, 0);
    check("lifo_pp_mid_pop", dout, 32'h2);
    step(POP, 0);
    mode = BUF;
    step(PUSH, 32'hDEAD);
    check("buf_dout0", dout, 32'hDEAD);
    check("buf_dv0", dout_valid, 1);
    step(POP, 32'hBEEF);
    check("buf_dout1", dout, 32'hBEEF);
    check("buf_dv1", dout_valid, 1);
    check("buf_count", count, 0);
    mode = INV;
    step(PUSH, 32'h1);
    check("inv_count", count, 0);
    check("inv_dv", dout_valid, 0);
    check("inv_dout", dout, 32'hBEEF);
    check("inv_pulses", {overflow, underflow, flushed}, 0);
    mode = FIFO;
    for (int i = 0; i < 5; i++) step(PUSH, 32'h100 + i);
    check("burst_count", count, 5);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_dout", dout, 0);
    check("async_rst_count", count, 0);
    check("async_rst_empty", empty, 1);
    check("async_rst_af", almost_full, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(PUSH, 32'hABC);
    check("post_rst_count", count, 1);
    check("post_rst_noflush", flushed, 0);
    step(POP, 0);
    check("post_rst_pop", dout, 32'hABC);
    check("post_rst_empty", empty, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_queue_ctrl.md
Name: stack_queue_ctrl

Overview:
- Parametrised successor to the fixed 4-entry LIFO/FIFO stage: one storage array that works as a FIFO queue, a LIFO stack or a registered pass-through buffer.
- Generalised data width and depth; adds true simultaneous push+pop, occupancy count, almost-full/almost-empty thresholds, overflow/underflow pulses and flush-on-mode-change.
- Sits between the address-mapped memory read path and the output buffer stage in top.

Parameters:
- DATA_W, 32, data width in bits.
- DEPTH, 8, number of entries; power of 2, minimum 2.
- AF_LVL, DEPTH-1, almost_full asserts when count >= AF_LVL.
- AE_LVL, 1, almost_empty asserts when count <= AE_LVL.
- CNT_W, $clog2(DEPTH+1), derived; width of count. Do not override.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- mode  input  2  0=BUFFER, 1=LIFO, 2=FIFO, 3=INVALID (team mode enum encoding).
- opcode  input  2  0=NIMIC, 1=PUSH, 2=POP, 3=PUSH_POP (team operation enum encoding).
- din  input  DATA_W  write data.
- dout  output  DATA_W  registered read data.
- dout_valid  output  1  one-cycle pulse: dout was updated this cycle.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- almost_full  output  1  high when count >= AF_LVL.
- almost_empty  output  1  high when count <= AE_LVL.
- overflow  output  1  one-cycle pulse: PUSH was rejected because storage was full.
- underflow  output  1  one-cycle pulse: POP was rejected because storage was empty.
- flushed  output  1  one-cycle pulse: storage was cleared by a mode change.

Behaviour:
- Reset (reset low, asynchronous):
  - dout=0, dout_valid=0, count=0, empty=1, full=0, almost_full=0, almost_empty=1, overflow/underflow/flushed=0.
  - wr_ptr=0, rd_ptr=0, mode_q=INVALID. Array contents are not cleared.
  - Release is synchronous to clk. Reset asserted mid-operation discards any in-flight operation.
- Registering: all outputs are registered. Flags are computed from the next-state count, so they are consistent with count in the same cycle.
- Mode tracking:
  - mode_q <= mode every cycle.
  - If mode != mode_q and count != 0: clear count and both pointers, pulse flushed, ignore opcode that cycle, dout_valid=0.
  - If mode != mode_q and count == 0: no flush pulse; opcode executes normally.
- BUFFER: dout <= din every cycle; dout_valid=1; opcode ignored; storage, count and pointers unchanged.
- INVALID: all opcodes ignored; dout holds; dout_valid=0; no pulses.
- FIFO mode:
  - PUSH, not full: mem[wr_ptr] <= din; wr_ptr+1 mod DEPTH; count+1.
  - PUSH, full: dropped; overflow=1; no state change.
  - POP, not empty: dout <= mem[rd_ptr]; rd_ptr+1 mod DEPTH; count-1; dout_valid=1.
  - POP, empty: underflow=1; dout holds.
  - PUSH_POP, count>0: read oldest and write din in the same cycle; both pointers advance; count unchanged; dout_valid=1. Legal when full.
  - PUSH_POP, empty: bypass. dout <= din, dout_valid=1, storage untouched, count stays 0.
- LIFO mode (wr_ptr is the stack pointer; rd_ptr is unused and held at 0):
  - PUSH, not full: mem[wr_ptr] <= din; wr_ptr+1; count+1.
  - PUSH, full: overflow=1; no state change.
  - POP, not empty: dout <= mem[wr_ptr-1]; wr_ptr-1; count-1; dout_valid=1.
  - POP, empty: underflow=1; no state change.
  - PUSH_POP, any count: dout <= din, dout_valid=1, storage/count/pointers unchanged. This equals a push followed by a pop and is legal when full or empty.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty are derived from count, never from pointer equality.
- Latency: one cycle from the opcode edge to dout/dout_valid/flags/pulses.
- NIMIC: no state change; dout holds; dout_valid=0; pulses 0.

Test Plan:
- DEPTH=8, FIFO: push 0x11..0x88. full=1 after the 8th push, almost_full from the 7th. A 9th push gives overflow=1 and count stays 8. 8 pops return 0x11..0x88 in order; then empty=1.
- LIFO: push 0xA, 0xB, 0xC, then 3 pops. dout = 0xC, 0xB, 0xA on consecutive cycles with dout_valid=1 each. A 4th pop gives underflow=1 and dout stays 0xA.
- FIFO full plus PUSH_POP din=0x99: dout=0x11, count stays 8, full stays 1. After 7 pops the final pop returns 0x99. FIFO empty PUSH_POP din=0x5 gives dout=0x5 next cycle, count=0.
- FIFO with 3 entries, switch mode to LIFO: flushed=1, count=0, empty=1, the op that cycle is ignored. Switching back to FIFO while empty gives no flushed pulse.
- BUFFER: din=0xDEAD then 0xBEEF gives dout=0xDEAD, then 0xBEEF, one cycle later each with dout_valid=1, and count unchanged. INVALID with PUSH gives count unchanged and no pulses.
- Assert reset low mid-burst (count=5, in FIFO) between clock edges: outputs go to reset values immediately, without waiting for clk. After release, a push then pop returns the new datum, not stale data.
